mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter downstream of the CPU store path. It consumes the core's store address/data bus plus a write strobe. Stores to its data register are queued in a small FIFO and serialised 8N1 on o_txd. The core never stalls: stores to a full FIFO are dropped and flagged.

Parameters:
BASE_ADDR, 32'h1000_0000, address of the TX data register; BASE_ADDR+4 is the control register.
CLK_DIV, 16, i_clk cycles per UART bit; legal range 2..65535.
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.

Ports:
i_clk  in  1  system clock; all state changes on the rising edge.
i_reset  in  1  reset, asynchronous, active-high.
i_wrEn  in  1  store strobe from the memory stage, valid for one cycle.
i_memAddr  in  32  store address.
i_memData  in  32  store data.
o_txd  out  1  serial output; idle high.
o_busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.
o_full  out  1  FIFO holds FIFO_DEPTH entries.
o_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
o_overflow  out  1  sticky flag: a store was dropped.

Behaviour:
- Reset (async assert, active-high): o_txd=1; o_busy=0; o_full=0; o_count=0; o_overflow=0; FSM=IDLE; FIFO pointers=0; bit and baud counters=0. Reset mid-frame aborts the frame immediately (o_txd=1 asynchronously).
- Address decode: exact 32-bit compare. Other addresses are ignored entirely.
- Data push: i_wrEn && i_memAddr==BASE_ADDR && !o_full pushes i_memData[7:0]. o_count updates at that edge.
- Full FIFO: the same store with o_full=1 is dropped. o_overflow is set at that edge. Fullness is evaluated before the edge, so a simultaneous pop does not admit the push.
- Control write: i_wrEn && i_memAddr==BASE_ADDR+4 && i_memData[0]=1 clears o_overflow. If a clear coincides with a dropped store in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when the FIFO is non-empty. The head byte is popped into a shift register at that edge.
  - START drives 0 for CLK_DIV cycles -> DATA.
  - DATA drives shift[0], LSB first. Each bit lasts CLK_DIV cycles. After 8 bits -> STOP.
  - STOP drives 1 for CLK_DIV cycles. At its last cycle: if the FIFO is non-empty, pop and go to START (no idle gap); else go to IDLE.
- Baud counter: counts 0..CLK_DIV-1 and wraps. It resets to 0 on every state entry.
- Latency: a store accepted at edge N makes o_count=1 after N. Pop and START entry occur at edge N+1, so o_txd falls after edge N+1. The frame lasts exactly 10*CLK_DIV cycles.
- Simultaneous push and pop: o_count is unchanged, and both operations take effect. There is no bypass; a push into an empty FIFO is still visible in o_count for one cycle.
- Pointer arithmetic: read/write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty are derived from o_count.
- o_txd is registered, with no combinational path from inputs.

Optional Feature:
Macro UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLK_DIV cycles, giving a frame length of 11*CLK_DIV.
- Undefined: no PARITY state exists; the frame is 8N1, 10*CLK_DIV cycles.

Test Plan:
- CLK_DIV=4. Reset, then store 0x0000_00A5 to 0x1000_0000 -> o_count=1 for one cycle, then o_txd drives, 4 cycles per bit, from edge N+1: 0, 1,0,1,0,0,1,0,1, then 1. o_busy drops after cycle 40 of the frame.
- Store 0x55, then 0x0F, on consecutive cycles -> two frames back-to-back with no idle cycle between the STOP of 0x55 and the START of 0x0F. Total 80 cycles.
- FIFO_DEPTH=4: issue 6 stores on consecutive cycles starting from idle -> first store popped at the next edge. 5 stores are accepted and the 6th dropped; o_overflow=1. Then store 1 to 0x1000_0004 -> o_overflow=0.
- Store 0x41 to 0x1000_0008, and a load-like cycle with i_wrEn=0 to 0x1000_0000 -> no push, o_count=0, o_txd stays 1.
- Assert i_reset during DATA bit 3 of 0xC3 -> o_txd=1 immediately; o_count=0 and o_busy=0. After release the FSM is IDLE, with no residual frame.
- UART_PARITY_EN defined: store 0x07 -> parity bit 1 appears after bit 7. The frame is 44 cycles at CLK_DIV=4.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO fed from the store bus, 8N1 serialiser.
// Define UART_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_wrEn,
    input  logic [31:0]                   i_memAddr,
    input  logic [31:0]                   i_memData,
    output logic                          o_txd,
    output logic                          o_busy,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow
);

    localparam int              PW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [15:0]     DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          par_q, par_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic data_sel, ctrl_sel, full, push, pop, bit_end;
    logic data_unused;

    assign data_unused = ^i_memData[31:8];

    assign data_sel = i_wrEn && (i_memAddr == BASE_ADDR);
    assign ctrl_sel = i_wrEn && (i_memAddr == BASE_ADDR + 32'd4);
    assign full     = (count_q == FULL_CNT);
    assign push     = data_sel && !full;
    assign bit_end  = (baud_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? 16'd0 : baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Parity is captured at pop time because the shifter consumes the byte.
        if (pop) begin
            shift_d = mem_q[rptr_q];
            par_d   = ^mem_q[rptr_q];
        end
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_PARITY_EN
            PARITY:  txd_d = par_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
        ovf_d   = ovf_q;
        if (data_sel && full) begin
            ovf_d = 1'b1;
        end else if (ctrl_sel && i_memData[0]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
            par_q   <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            par_q   <= par_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wptr_q] <= i_memData[7:0];
    end

    assign o_txd      = txd_q;
    assign o_busy     = (count_q != '0) || (state_q != IDLE);
    assign o_full     = full;
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-position reference model, directed and random stores.
module tb_mmio_uart_tx;

    localparam int          DIV   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h1000_0000;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic        txd, busy, full, ovf;
    logic [2:0]  cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a byte queue plus the position inside the frame on the wire.
    logic [7:0] mq[$];
    bit         act;
    int         pos;
    logic [7:0] cur;
    bit         m_ovf;

    mmio_uart_tx #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (DIV),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_wrEn    (wr),
        .i_memAddr (addr),
        .i_memData (data),
        .o_txd     (txd),
        .o_busy    (busy),
        .o_full    (full),
        .o_count   (cnt),
        .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic exp_bit();
        int idx;
        idx = pos / DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return cur[idx-1];
`ifdef UART_PARITY_EN
        if (idx == 9) return ^cur;
`endif
        return 1'b1;
    endfunction

    function automatic logic [6:0] exp_vec();
        logic t;
        t = act ? exp_bit() : 1'b1;
        return {t, act || (mq.size() > 0), mq.size() == DEPTH,
                3'(mq.size()), m_ovf};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {txd, busy, full, cnt, ovf};
    endfunction

    task automatic model_reset();
        mq.delete();
        act   = 0;
        pos   = 0;
        m_ovf = 0;
    endtask

    task automatic model_edge(input logic w, input logic [31:0] a,
                              input logic [31:0] d);
        bit was_full;
        was_full = (mq.size() == DEPTH);
        if (act) begin
            pos++;
            if (pos == FRAME) act = 0;
        end
        if (!act && mq.size() > 0) begin
            cur = mq.pop_front();
            act = 1;
            pos = 0;
        end
        if (w && a == BASE) begin
            if (!was_full) mq.push_back(d[7:0]);
            else m_ovf = 1;
        end else if (w && a == BASE + 32'd4 && d[0]) begin
            m_ovf = 0;
        end
    endtask

    task automatic step(input logic w, input logic [31:0] a,
                        input logic [31:0] d);
        wr   = w;
        addr = a;
        data = d;
        @(posedge clk);
        model_edge(w, a, d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (dut_vec() !== 7'b1_0_0_000_0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", dut_vec(), 7'b1000000);
        end
        rst = 1'b0;
        model_reset();
        step(0, 0, 0);
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        int busy_cyc;
        step(1, BASE, 32'h0000_00A5);
        n_tests++;
        if (cnt !== 3'd1 || txd !== 1'b1) begin
            n_fail++;
            $display("FAIL single_push: got cnt=%0d txd=%b want cnt=1 txd=1", cnt, txd);
        end
        step(0, 0, 0);
        n_tests++;
        if (cnt !== 3'd0 || txd !== 1'b0) begin
            n_fail++;
            $display("FAIL single_start: got cnt=%0d txd=%b want cnt=0 txd=0", cnt, txd);
        end
        busy_cyc = 0;
        for (int i = 1; i <= FRAME + 2; i++) begin
            step(0, 0, 0);
            if (busy) busy_cyc++;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_frame cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if (busy_cyc !== FRAME - 1) begin
            n_fail++;
            $display("FAIL single_busy_len: got %0d want %0d", busy_cyc, FRAME - 1);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cyc;
        busy_cyc = 0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            if (i == 0) step(1, BASE, 32'h55);
            else if (i == 1) step(1, BASE, 32'h0F);
            else step(0, 0, 0);
            if (busy) busy_cyc++;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if (busy_cyc !== 2 * FRAME + 1) begin
            n_fail++;
            $display("FAIL b2b_busy_len: got %0d want %0d", busy_cyc, 2 * FRAME + 1);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) begin
            step(1, BASE, $urandom);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_fill %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if (cnt !== 3'd4 || ovf !== 1'b1 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got cnt=%0d ovf=%b full=%b want 4 1 1", cnt, ovf, full);
        end
        step(1, BASE + 32'd4, 32'd1);
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b want 0", ovf);
        end
        for (int i = 0; i < 6 * FRAME && (act || mq.size() > 0); i++) begin
            step(0, 0, 0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_drain cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_decode();
        step(1, BASE + 32'd8, 32'h41);
        step(0, BASE, 32'h41);
        n_tests++;
        if (cnt !== 3'd0 || txd !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL decode: got cnt=%0d txd=%b busy=%b want 0 1 0", cnt, txd, busy);
        end
        for (int i = 0; i < 2 * DIV; i++) begin
            step(0, 0, 0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL decode_idle cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1, BASE, 32'hC3);
        step(1, BASE, 32'h11);
        for (int i = 0; i < 4 * DIV; i++) step(0, 0, 0);
        n_tests++;
        if (dut_vec() !== exp_vec() || txd !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_bit3: got %b want %b", dut_vec(), exp_vec());
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (txd !== 1'b1 || cnt !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got txd=%b cnt=%0d busy=%b want 1 0 0", txd, cnt, busy);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(0, 0, 0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL post_reset cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 39);
            if (r < 3) step(1, BASE, $urandom);
            else if (r == 3) step(1, BASE + 32'd4, $urandom);
            else if (r == 4) step(1, BASE + 32'd8, $urandom);
            else if (r == 5) step(0, BASE, $urandom);
            else step(0, 0, 0);
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_decode();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
